// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage register: valid/ready handshake with a one-entry skid
// buffer, synchronous flush to a NOP bubble, and a saturating stall counter.
// Every output is driven straight from a flop; the next-state logic computes
// the post-edge value of each output alongside the storage state.
module pipe_stage_reg #(
  parameter int unsigned            WIDTH     = 32,
  parameter logic [WIDTH-1:0]       NOP_VALUE = '0,
  parameter int unsigned            CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt,
  input  logic             stall_clr
);

  localparam int unsigned OCC_W = 2;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Current state
  logic             main_valid;
  logic [WIDTH-1:0] main_data;
  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;

  // Next state
  logic             main_valid_n;
  logic [WIDTH-1:0] main_data_n;
  logic             skid_valid_n;
  logic [WIDTH-1:0] skid_data_n;
  logic             in_ready_n;
  logic [OCC_W-1:0] occupancy_n;
  logic [CNT_W-1:0] stall_cnt_n;

  // Handshake qualifiers
  logic accept;
  logic load_en;
  logic stalled;

  assign accept  = in_valid & in_ready;
  assign load_en = ~main_valid | out_ready;
  assign stalled = main_valid & ~out_ready;

  // main_data doubles as out_data, so it is parked at NOP_VALUE whenever the
  // main register goes empty; the output then needs no mux behind the flop.
  assign out_valid = main_valid;
  assign out_data  = main_data;

  // Next-state logic for the main/skid registers, flush has top priority
  always_comb begin
    main_valid_n = main_valid;
    main_data_n  = main_data;
    skid_valid_n = skid_valid;
    skid_data_n  = skid_data;

    if (flush) begin
      main_valid_n = 1'b0;
      main_data_n  = NOP_VALUE;
      skid_valid_n = 1'b0;
    end else if (load_en) begin
      if (skid_valid) begin
        // in_ready was low, so no beat can be accepted this edge
        main_valid_n = 1'b1;
        main_data_n  = skid_data;
        skid_valid_n = 1'b0;
      end else if (accept) begin
        main_valid_n = 1'b1;
        main_data_n  = in_data;
      end else begin
        main_valid_n = 1'b0;
        main_data_n  = NOP_VALUE;
      end
    end else if (accept) begin
      skid_valid_n = 1'b1;
      skid_data_n  = in_data;
    end

    in_ready_n  = ~skid_valid_n;
    occupancy_n = OCC_W'(main_valid_n) + OCC_W'(skid_valid_n);
  end

  // Saturating stall counter; clear wins over increment, flush is ignored
  always_comb begin
    stall_cnt_n = stall_cnt;
    if (stall_clr) begin
      stall_cnt_n = '0;
    end else if (stalled && (stall_cnt != CNT_MAX)) begin
      stall_cnt_n = stall_cnt + CNT_W'(1);
    end
  end

  // Storage and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_valid <= 1'b0;
      main_data  <= NOP_VALUE;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      in_ready   <= 1'b1;
      occupancy  <= '0;
      stall_cnt  <= '0;
    end else begin
      main_valid <= main_valid_n;
      main_data  <= main_data_n;
      skid_valid <= skid_valid_n;
      skid_data  <= skid_data_n;
      in_ready   <= in_ready_n;
      occupancy  <= occupancy_n;
      stall_cnt  <= stall_cnt_n;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and randomized checks for pipe_stage_reg. A second instance with a
// 2-bit stall counter shares all inputs to exercise counter saturation.
module tb_pipe_stage_reg;

  localparam int unsigned WIDTH = 32;
  localparam logic [WIDTH-1:0] NOP = 32'hDEAD_BEEF;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             flush;
  logic [1:0]       occupancy;
  logic [15:0]      stall_cnt;
  logic             stall_clr;

  logic             in_ready2;
  logic             out_valid2;
  logic [WIDTH-1:0] out_data2;
  logic [1:0]       occupancy2;
  logic [1:0]       stall_cnt2;

  int errors;
  int checks;
  logic [31:0] q[$];
  logic [31:0] exp_word;

  pipe_stage_reg #(.WIDTH(WIDTH), .NOP_VALUE(NOP), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .flush(flush), .occupancy(occupancy),
    .stall_cnt(stall_cnt), .stall_clr(stall_clr)
  );

  pipe_stage_reg #(.WIDTH(WIDTH), .NOP_VALUE(NOP), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
    .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
    .flush(flush), .occupancy(occupancy2),
    .stall_cnt(stall_cnt2), .stall_clr(stall_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Advance one edge; inputs set after this take effect on the next edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    flush     = 1'b0;
    stall_clr = 1'b0;

    // Reset values
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  out_data, NOP);
    chk("rst_in_ready",  32'(in_ready), 32'd1);
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    step();

    // Streaming at full throughput
    in_valid = 1'b1; in_data = 32'h11; out_ready = 1'b1;
    step();
    chk("stream_v0", 32'(out_valid), 32'd1);
    chk("stream_d0", out_data, 32'h11);
    chk("stream_r0", 32'(in_ready), 32'd1);
    in_data = 32'h22;
    step();
    chk("stream_d1", out_data, 32'h22);
    chk("stream_r1", 32'(in_ready), 32'd1);
    in_data = 32'h33;
    step();
    chk("stream_d2", out_data, 32'h33);
    chk("stream_r2", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    step();
    chk("stream_empty_v", 32'(out_valid), 32'd0);
    chk("stream_empty_d", out_data, NOP);
    chk("stream_stall",   32'(stall_cnt), 32'd0);

    // Back-pressure into the skid buffer
    in_valid = 1'b1; in_data = 32'h0A; out_ready = 1'b0;
    step();
    chk("bp_occ1", 32'(occupancy), 32'd1);
    in_data = 32'h0B;
    step();
    in_valid = 1'b0;
    chk("bp_occ2",   32'(occupancy), 32'd2);
    chk("bp_ready0", 32'(in_ready), 32'd0);
    chk("bp_hold_a", out_data, 32'h0A);
    out_ready = 1'b1;
    step();
    chk("bp_out_b",  out_data, 32'h0B);
    chk("bp_ready1", 32'(in_ready), 32'd1);
    chk("bp_occ_b",  32'(occupancy), 32'd1);
    step();
    chk("bp_drained", 32'(out_valid), 32'd0);

    // Flush with both registers full
    in_valid = 1'b1; in_data = 32'h55; out_ready = 1'b0;
    step();
    in_data = 32'h66;
    step();
    chk("fl_occ2", 32'(occupancy), 32'd2);
    flush = 1'b1; in_data = 32'h0C;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_valid", 32'(out_valid), 32'd0);
    chk("fl_data",  out_data, NOP);
    chk("fl_occ0",  32'(occupancy), 32'd0);
    chk("fl_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    step();
    chk("fl_no_c", 32'(out_valid), 32'd0);

    // Flush discards a beat accepted in the same cycle
    in_valid = 1'b1; in_data = 32'h77;
    step();
    chk("fl2_load", out_data, 32'h77);
    flush = 1'b1; in_data = 32'h0C;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl2_valid", 32'(out_valid), 32'd0);
    step();
    chk("fl2_no_c", 32'(out_valid), 32'd0);

    // Stall counter, including saturation of the 2-bit instance
    stall_clr = 1'b1;
    step();
    stall_clr = 1'b0;
    chk("st_clr0",  32'(stall_cnt),  32'd0);
    chk("st2_clr0", 32'(stall_cnt2), 32'd0);
    in_valid = 1'b1; in_data = 32'h99; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    chk("st_load0", 32'(stall_cnt), 32'd0);
    for (int i = 0; i < 5; i++) step();
    chk("st_five",  32'(stall_cnt),  32'd5);
    chk("st2_sat5", 32'(stall_cnt2), 32'd3);
    step();
    chk("st_six",   32'(stall_cnt),  32'd6);
    chk("st2_sat6", 32'(stall_cnt2), 32'd3);
    stall_clr = 1'b1;
    step();
    stall_clr = 1'b0;
    chk("st_clr_pri",  32'(stall_cnt),  32'd0);
    chk("st2_clr_pri", 32'(stall_cnt2), 32'd0);
    step();
    chk("st_resume", 32'(stall_cnt), 32'd1);

    // Asynchronous reset with occupancy=2
    in_valid = 1'b1; in_data = 32'hAB;
    step();
    chk("ar_occ2", 32'(occupancy), 32'd2);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_valid", 32'(out_valid), 32'd0);
    chk("ar_data",  out_data, NOP);
    chk("ar_ready", 32'(in_ready), 32'd1);
    chk("ar_occ0",  32'(occupancy), 32'd0);
    chk("ar_stall", 32'(stall_cnt), 32'd0);
    step();
    chk("ar_ignored", 32'(out_valid), 32'd0);
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b1; in_data = 32'h44; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("ar_after_v", 32'(out_valid), 32'd1);
    chk("ar_after_d", out_data, 32'h44);
    step();

    // Randomized traffic against a FIFO scoreboard
    q.delete();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 3) != 0);
      in_data   = $urandom;
      @(negedge clk);
      if (occupancy > 2'd2 || 32'(occupancy) != 32'(q.size()))
        chk("rnd_occ", 32'(occupancy), 32'(q.size()));
      if (in_ready != (occupancy != 2'd2))
        chk("rnd_ready_full", 32'(in_ready), 32'(occupancy != 2'd2));
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("rnd_underflow", 32'(out_valid), 32'd0);
        end else begin
          exp_word = q.pop_front();
          chk("rnd_data", out_data, exp_word);
        end
      end
      if (in_valid && in_ready) q.push_back(in_data);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("tail_underflow", 32'(out_valid), 32'd0);
        end else begin
          exp_word = q.pop_front();
          chk("tail_data", out_data, exp_word);
        end
      end
      step();
    end
    chk("tail_empty", 32'(q.size()), 32'd0);
    chk("tail_occ",   32'(occupancy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
